// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//
// Linear chain of DEPTH registered stages with a valid/ready handshake at each
// end. Every stage can be discarded individually through a per-stage flush mask.
// An item advances whenever the slot ahead of it frees up during the same cycle,
// so a completely full chain still sustains one item per cycle.
//
// Ports
//   i_clk          rising-edge clock
//   i_s_rst_n      synchronous active-low reset
//   i_valid        input item present
//   i_data         input payload
//   o_ready        chain accepts the input this cycle (no path from i_valid/i_data)
//   o_valid        output item present (stage DEPTH-1, unless it is being flushed)
//   o_data         output payload (stage DEPTH-1 contents)
//   i_out_ready    downstream accepts the output
//   i_flush        per-stage discard mask, bit k targets stage k (pre-edge contents)
//   o_stage_valid  per-stage valid bits
//   o_occupancy    number of valid stages
//   o_flush_cnt    saturating count of discarded items
//   o_stall_cnt    saturating count of cycles with o_valid & ~i_out_ready

module pipe_stage_chain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned OccW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_s_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_out_ready,
  input  logic [DEPTH-1:0] i_flush,
  output logic [DEPTH-1:0] o_stage_valid,
  output logic [OccW-1:0]  o_occupancy,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  function automatic logic [OccW-1:0] popcnt(input logic [DEPTH-1:0] x);
    logic [OccW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      c = c + OccW'(x[i]);
    end
    return c;
  endfunction

  // Stage state
  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;

  // Per-stage handshake terms
  logic [DEPTH-1:0] adv;   // item in stage k leaves it at the next edge
  logic [DEPTH-1:0] free;  // stage k can take a new item at the next edge
  logic             accept;

  // Statistics
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W:0]   flush_sum;

  // A flushed output stage never presents its item.
  assign o_valid = v_q[DEPTH-1] & ~i_flush[DEPTH-1];
  assign o_data  = d_q[DEPTH-1];

  // Free/advance ripple from the output end towards the input end. Only
  // registered state, flush and i_out_ready feed this, keeping i_valid and
  // i_data off the o_ready path.
  always_comb begin
    adv             = '0;
    free            = '0;
    adv[DEPTH-1]    = o_valid & i_out_ready;
    free[DEPTH-1]   = ~v_q[DEPTH-1] | i_flush[DEPTH-1] | adv[DEPTH-1];
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      adv[k]  = v_q[k] & ~i_flush[k] & free[k+1];
      free[k] = ~v_q[k] | i_flush[k] | adv[k];
    end
  end

  // Reset blocks acceptance while it is asserted.
  assign o_ready = i_s_rst_n & free[0];
  assign accept  = i_valid & o_ready;

  // Next stage contents: a stage is loaded from behind (or from the input for
  // stage 0), holds a surviving item that is not leaving, or empties. The
  // payload of an empty stage keeps its last value.
  always_comb begin
    v_d    = '0;
    d_d    = d_q;
    v_d[0] = accept | (v_q[0] & ~i_flush[0] & ~adv[0]);
    if (accept) begin
      d_d[0] = i_data;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      v_d[k] = adv[k-1] | (v_q[k] & ~i_flush[k] & ~adv[k]);
      if (adv[k-1]) begin
        d_d[k] = d_q[k-1];
      end
    end
  end

  // Counters saturate at all-ones. The flush increment is at most DEPTH, so one
  // extra sum bit is enough to detect overflow.
  always_comb begin
    flush_sum   = {1'b0, flush_cnt_q} + (CNT_W + 1)'(popcnt(v_q & i_flush));
    flush_cnt_d = flush_sum[CNT_W] ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
    stall_cnt_d = stall_cnt_q;
    if (o_valid && !i_out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Reset wins over every transfer, flush and counter update in the same cycle,
  // so in-flight items are dropped without being counted as flushed.
  always_ff @(posedge i_clk) begin
    if (!i_s_rst_n) begin
      v_q         <= '0;
      d_q         <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      d_q         <= d_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stage_valid = v_q;
  assign o_occupancy   = popcnt(v_q);
  assign o_flush_cnt   = flush_cnt_q;
  assign o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;

  localparam int W    = 32;
  localparam int D    = 4;
  localparam int CW   = 4;
  localparam int OW   = $clog2(D + 1);
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          i_s_rst_n;
  logic          i_valid;
  logic [W-1:0]  i_data;
  logic          o_ready;
  logic          o_valid;
  logic [W-1:0]  o_data;
  logic          i_out_ready;
  logic [D-1:0]  i_flush;
  logic [D-1:0]  o_stage_valid;
  logic [OW-1:0] o_occupancy;
  logic [CW-1:0] o_flush_cnt;
  logic [CW-1:0] o_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_chain #(
    .WIDTH(W),
    .DEPTH(D),
    .CNT_W(CW)
  ) dut (
    .i_clk        (clk),
    .i_s_rst_n    (i_s_rst_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_out_ready  (i_out_ready),
    .i_flush      (i_flush),
    .o_stage_valid(o_stage_valid),
    .o_occupancy  (o_occupancy),
    .o_flush_cnt  (o_flush_cnt),
    .o_stall_cnt  (o_stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;

  // Scoreboard: items in the order they must leave the chain.
  typedef struct {
    int           id;
    logic [W-1:0] data;
  } item_t;
  item_t exp_q[$];

  // Reference model: which slot each live item sits in, plus counters.
  bit [D-1:0]   mv;
  logic [W-1:0] md[D];
  int           mid[D];
  int           next_id = 0;
  int           m_fcnt  = 0;
  int           m_scnt  = 0;

  // Values seen on the DUT in the current cycle (sampled mid-cycle).
  logic          s_ready, s_valid;
  logic [W-1:0]  s_data;
  logic [OW-1:0] s_occ;
  logic [D-1:0]  s_sv;
  logic [CW-1:0] s_fcnt, s_scnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // An item is stuck when it survives the flush and the slot ahead is occupied
  // by an item that is itself stuck (or, at the end, downstream refuses it).
  function automatic bit [D-1:0] m_stuck(input logic [D-1:0] fl, input bit ordy);
    bit [D-1:0] st;
    bit [D-1:0] sv;
    sv      = mv & ~fl;
    st      = '0;
    st[D-1] = sv[D-1] & !ordy;
    for (int k = D - 2; k >= 0; k--) st[k] = sv[k] & st[k+1];
    return st;
  endfunction

  task automatic m_commit(input bit rn, input bit v, input logic [W-1:0] dt,
                          input logic [D-1:0] fl, input bit ordy);
    bit [D-1:0]   st, sv, nv;
    logic [W-1:0] nd[D];
    int           nid[D];
    int           nfl;
    if (!rn) begin
      mv = '0;
      exp_q.delete();
      m_fcnt = 0;
      m_scnt = 0;
    end else begin
      sv  = mv & ~fl;
      st  = m_stuck(fl, ordy);
      nfl = 0;
      for (int k = 0; k < D; k++) begin
        if (mv[k] && fl[k]) begin
          nfl++;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].id == mid[k]) begin
              exp_q.delete(i);
              break;
            end
          end
        end
      end
      m_fcnt = (m_fcnt + nfl > MAXC) ? MAXC : m_fcnt + nfl;
      if (sv[D-1] && !ordy && m_scnt < MAXC) m_scnt++;
      nv = '0;
      for (int k = 0; k < D; k++) begin
        nd[k]  = md[k];
        nid[k] = mid[k];
      end
      for (int k = 0; k < D; k++) begin
        if (sv[k]) begin
          if (st[k]) begin
            nv[k]  = 1'b1;
            nd[k]  = md[k];
            nid[k] = mid[k];
          end else if (k < D - 1) begin
            nv[k+1]  = 1'b1;
            nd[k+1]  = md[k];
            nid[k+1] = mid[k];
          end
        end
      end
      if (v && !st[0]) begin
        nv[0]  = 1'b1;
        nd[0]  = dt;
        nid[0] = next_id;
        exp_q.push_back(item_t'{id: next_id, data: dt});
        next_id++;
      end
      mv = nv;
      for (int k = 0; k < D; k++) begin
        md[k]  = nd[k];
        mid[k] = nid[k];
      end
    end
  endtask

  // One clock cycle: drive just after the rising edge, sample and compare at the
  // falling edge, then advance the model at the next rising edge.
  task automatic cyc(input bit rn, input bit v, input logic [W-1:0] dt,
                     input logic [D-1:0] fl, input bit ordy);
    bit [D-1:0] st;
    bit         m_ready, m_ov;
    i_s_rst_n   = rn;
    i_valid     = v;
    i_data      = dt;
    i_flush     = fl;
    i_out_ready = ordy;
    st      = m_stuck(fl, ordy);
    m_ready = rn && !st[0];
    m_ov    = mv[D-1] && !fl[D-1];
    @(negedge clk);
    s_ready = o_ready;
    s_valid = o_valid;
    s_data  = o_data;
    s_occ   = o_occupancy;
    s_sv    = o_stage_valid;
    s_fcnt  = o_flush_cnt;
    s_scnt  = o_stall_cnt;
    check("o_ready", 64'(s_ready), 64'(m_ready));
    check("o_valid", 64'(s_valid), 64'(m_ov));
    check("o_stage_valid", 64'(s_sv), 64'(mv));
    check("o_occupancy", 64'(s_occ), 64'($countones(mv)));
    check("o_flush_cnt", 64'(s_fcnt), 64'(m_fcnt));
    check("o_stall_cnt", 64'(s_scnt), 64'(m_scnt));
    @(posedge clk);
    m_commit(rn, v, dt, fl, ordy);
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, '0, ordy);
  endtask

  // Monitor: every accepted output must be the next expected survivor.
  always @(negedge clk) begin
    item_t it;
    if (i_s_rst_n && o_valid && i_out_ready) begin
      n_xfer++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output at %0t: got data 0x%0h, want no output", $time, o_data);
      end else begin
        it = exp_q.pop_front();
        if (o_data !== it.data) begin
          n_fail++;
          $display("FAIL out_data at %0t: got 0x%0h, want 0x%0h", $time, o_data, it.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sv3[3];
    int           peak;
    int           x0;
    mv = '0;
    for (int k = 0; k < D; k++) begin
      md[k]  = '0;
      mid[k] = -1;
    end
    i_s_rst_n   = 1'b0;
    i_valid     = 1'b0;
    i_data      = '0;
    i_flush     = '0;
    i_out_ready = 1'b0;
    #1;

    // Reset: o_ready low while held, everything zero and o_ready high after.
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, '0, 1'b1);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, '0, 1'b1);
    check("rst_hold_ready", 64'(s_ready), 64'd0);
    cyc(1'b1, 1'b0, '0, '0, 1'b1);
    check("rst_rel_ready", 64'(s_ready), 64'd1);
    check("rst_data", 64'(s_data), 64'd0);
    check("rst_occ", 64'(s_occ), 64'd0);

    // Stream: three items, each visible DEPTH cycles after acceptance.
    sv3[0] = 32'h11;
    sv3[1] = 32'h22;
    sv3[2] = 32'h33;
    peak   = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, c < 3, (c < 3) ? sv3[c] : '0, '0, 1'b1);
      if (int'(s_occ) > peak) peak = int'(s_occ);
      if (c >= 4 && c <= 6) begin
        check("stream_valid", 64'(s_valid), 64'd1);
        check("stream_data", 64'(s_data), 64'(sv3[c-4]));
      end
    end
    check("stream_peak_occ", 64'(peak), 64'd3);

    // Backpressure: four accepted, o_ready drops in cycle 4.
    cyc(1'b0, 1'b0, '0, '0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, 1'b1, 32'hB0 + c, '0, 1'b0);
      check("bp_ready", 64'(s_ready), (c < 4) ? 64'd1 : 64'd0);
      if (c == 5) check("bp_stall_c5", 64'(s_scnt), 64'd1);
    end
    cyc(1'b1, 1'b0, '0, '0, 1'b0);
    check("bp_occ", 64'(s_occ), 64'd4);
    check("bp_stall", 64'(s_scnt), 64'd2);

    // Flush the middle two stages; stage 0 refills in the same cycle.
    cyc(1'b1, 1'b1, 32'hE0, 4'b0110, 1'b0);
    cyc(1'b1, 1'b0, '0, '0, 1'b0);
    check("fl_cnt", 64'(s_fcnt), 64'd2);
    check("fl_occ", 64'(s_occ), 64'd3);
    cyc(1'b1, 1'b0, '0, '0, 1'b1);
    check("fl_first", 64'(s_data), 64'hB0);
    cyc(1'b1, 1'b0, '0, '0, 1'b1);
    check("fl_second", 64'(s_data), 64'hB3);
    idle(6, 1'b1);

    // Full rate with a full chain.
    for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, 32'hF000 + c, '0, 1'b0);
    x0 = n_xfer;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, 1'b1, 32'hF100 + c, '0, 1'b1);
      check("fr_ready", 64'(s_ready), 64'd1);
      check("fr_occ", 64'(s_occ), 64'd4);
    end
    check("fr_xfers", 64'(n_xfer - x0), 64'd10);
    idle(6, 1'b1);

    // Reset with three items in flight.
    for (int c = 0; c < 3; c++) cyc(1'b1, 1'b1, 32'hA0 + c, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    x0 = n_xfer;
    cyc(1'b1, 1'b0, '0, '0, 1'b1);
    check("mr_stage_valid", 64'(s_sv), 64'd0);
    check("mr_fcnt", 64'(s_fcnt), 64'd0);
    check("mr_scnt", 64'(s_scnt), 64'd0);
    idle(8, 1'b1);
    check("mr_no_output", 64'(n_xfer - x0), 64'd0);

    // Stall counter saturation at 15.
    cyc(1'b0, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 1'b1, 32'h5A5A, '0, 1'b0);
    idle(24, 1'b0);
    check("sat_stall", 64'(s_scnt), 64'd15);
    idle(3, 1'b0);
    check("sat_hold", 64'(s_scnt), 64'd15);
    idle(4, 1'b1);

    // Random traffic with flushes and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      cyc($urandom_range(0, 299) != 0, ($urandom % 4) != 0, $urandom,
          (($urandom % 8) == 0) ? D'($urandom) : '0, ($urandom % 4) != 0);
    end
    idle(10, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Parameters
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 4: number of pipeline stages (2..8).
REQ-003 SHALL have parameter CNT_W, default 16: width of the statistics counters (4..32).

Interface
REQ-004 i_clk  in  1  rising-edge clock; single clock domain.
REQ-005 i_s_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_valid  in  1  input item present.
REQ-007 i_data  in  WIDTH  input payload.
REQ-008 o_ready  out  1  chain accepts the input this cycle.
REQ-009 o_valid  out  1  output item present.
REQ-010 o_data  out  WIDTH  output payload (stage DEPTH-1 contents).
REQ-011 i_out_ready  in  1  downstream accepts the output.
REQ-012 i_flush  in  DEPTH  per-stage discard mask; bit k targets stage k.
REQ-013 o_stage_valid  out  DEPTH  per-stage valid bits.
REQ-014 o_occupancy  out  clog2(DEPTH+1)  count of valid stages.
REQ-015 o_flush_cnt  out  CNT_W  saturating count of discarded items.
REQ-016 o_stall_cnt  out  CNT_W  saturating count of output-stall cycles.

Function
REQ-017 Each stage k SHALL hold a registered valid bit v[k] and a WIDTH-bit payload d[k]; stage 0 is the input end and stage DEPTH-1 is the output end.
REQ-018 Output handshake: o_valid = v[DEPTH-1] & ~i_flush[DEPTH-1]; o_data = d[DEPTH-1]; a transfer occurs when o_valid & i_out_ready.
REQ-019 Free[k] (slot k can accept next edge) SHALL be: ~v[k] | i_flush[k] | adv[k], where adv[DEPTH-1] = o_valid & i_out_ready.
REQ-020 adv[k] for k<DEPTH-1 SHALL be v[k] & ~i_flush[k] & free[k+1].
REQ-021 o_ready SHALL equal free[0]; an input is accepted when i_valid & o_ready.
REQ-022 On each edge:
  - each advancing item SHALL move from k to k+1 with its payload;
  - an accepted input SHALL load stage 0;
  - a stage that is neither loaded nor holding SHALL clear v[k].
REQ-023 Flush SHALL apply to pre-edge contents only.
  - A valid stage k with i_flush[k]=1 SHALL be discarded: not forwarded, not output.
  - An item moving into a flushed stage k in the same cycle SHALL land normally.
REQ-024 The order of surviving items SHALL be preserved and no item SHALL be duplicated.
REQ-025 Without stalls or flushes, an item accepted in cycle n SHALL appear on o_data with o_valid=1 in cycle n+DEPTH.
REQ-026 Throughput SHALL be one item per cycle when i_out_ready=1 continuously, including with all stages full.
REQ-027 o_occupancy SHALL equal popcount(v) (registered state).
REQ-028 o_flush_cnt SHALL add popcount(v & i_flush) each cycle and saturate at 2^CNT_W-1 without wrapping.
REQ-029 o_stall_cnt SHALL increment in each cycle with o_valid & ~i_out_ready, saturating at 2^CNT_W-1.
REQ-030 d[k] of an invalid stage SHALL hold its last value; it is don't-care for checking.
REQ-031 No combinational path SHALL exist from i_valid or i_data to o_ready.

Reset
REQ-032 While i_s_rst_n=0 at an edge, every v[k], d[k], o_flush_cnt and o_stall_cnt SHALL be 0 after that edge.
REQ-033 While i_s_rst_n=0, o_ready SHALL be 0 and no input SHALL be accepted.
REQ-034 Reset SHALL override flush, transfers and counter updates in the same cycle.
REQ-035 Reset mid-operation SHALL drop all in-flight items and not count them as flushed.
REQ-036 All outputs SHALL be 0 after reset, except o_ready, which SHALL be 1 in the first cycle after reset releases.

Verification (DEPTH=4, WIDTH=32 unless noted)
REQ-037 Stream test: after reset, with i_out_ready=1, drive 0x11, 0x22, 0x33 in cycles 0-2 -> o_data shows 0x11, 0x22, 0x33 in cycles 4-6; o_occupancy peaks at 3.
REQ-038 Backpressure test: with i_out_ready=0, drive i_valid=1 for 6 cycles -> 4 items accepted; o_ready=0 from cycle 4; o_occupancy=4; o_stall_cnt increments by 1 per cycle while o_valid=1.
REQ-039 Flush test: full chain holding A,B,C,D (D at output), i_out_ready=0, i_flush=4'b0110 for one cycle -> B and C discarded; o_flush_cnt=2; o_occupancy=2 plus any accepted input; the next outputs are D then A.
REQ-040 Full-rate test: full chain, i_valid=1 and i_out_ready=1 for 10 cycles -> 10 transfers in order; o_occupancy stays 4; o_ready stays 1.
REQ-041 Reset mid-stream: i_s_rst_n=0 for one cycle with 3 items in flight -> o_stage_valid=0, counters=0, no o_valid for those items afterward.
REQ-042 Saturation test (CNT_W=4): o_valid=1 with i_out_ready=0 for 20 cycles -> o_stall_cnt=15 and holds at 15.
